// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, NOP encoding and FSM encoding for the IF stage
package fetch_unit_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;

    localparam logic [15:0] NOP_INSTR = 16'hF01C;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory read bus between the IF stage and memory
interface fetch_unit_if #(
  parameter int W = 16
) ();
  logic         i_readM;
  logic [W-1:0] i_address;
  logic [W-1:0] i_data;
  logic         i_inputReady;

  modport master (output i_readM, output i_address, input i_data, input i_inputReady);
  modport slave  (input i_readM, input i_address, output i_data, output i_inputReady);
endinterface

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry skid buffer for {instr, PC, pred_PC} caught during a stall
module fetch_hold_buf #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic           clear,
  input  logic [3*W-1:0] d,
  output logic           valid,
  output logic [3*W-1:0] q
);
  logic           valid_q, valid_d;
  logic [3*W-1:0] data_q, data_d;

  // clear wins so a redirect in the same cycle can never leave stale data marked valid
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
    if (clear) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: owns PC, issues imem reads, fills IF/ID, handles stalls and redirects
// Optional fetch/flush counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fetch_unit_if.master         imem,
  output logic [WORD_SIZE-1:0] PC,
  input  logic [WORD_SIZE-1:0] pred_next_PC,
  input  logic                 stall_if,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_PC,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_PC,
  output logic [WORD_SIZE-1:0] if_id_pred_PC,
  output logic [15:0]          num_fetched,
  output logic [15:0]          num_flush
);
  localparam int W = WORD_SIZE;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   pc_q, pc_d, req_addr_q, req_addr_d;
  logic           readm_q, readm_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   instr_q, instr_d, ifpc_q, ifpc_d, ifpred_q, ifpred_d;
  logic           ifid_load, buf_load, buf_clear, buf_valid;
  logic [3*W-1:0] ld_data, buf_q, cap_data;

  assign cap_data = {imem.i_data, req_addr_q, pred_next_PC};

  fetch_hold_buf #(.W(W)) u_hold_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .d       (cap_data),
    .valid   (buf_valid),
    .q       (buf_q)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    readm_d    = readm_q;
    vld_d      = vld_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    ifpred_d   = ifpred_q;
    ifid_load  = 1'b0;
    ld_data    = cap_data;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          pc_d      = redirect_PC;
          vld_d     = 1'b0;
          buf_clear = 1'b1;
          // an outstanding read must still complete on the bus before refetching
          if (readm_q && !imem.i_inputReady) state_d = ST_DISCARD;
          else readm_d = 1'b0;
        end else if (readm_q && imem.i_inputReady) begin
          readm_d = 1'b0;
          if (stall_if) begin
            buf_load = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else begin
          if (!readm_q) begin
            readm_d    = 1'b1;
            req_addr_d = pc_q;
          end
          if (!stall_if) vld_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d      = redirect_PC;
          vld_d     = 1'b0;
          buf_clear = 1'b1;
          state_d   = ST_FETCH;
        end else if (!stall_if && buf_valid) begin
          ifid_load = 1'b1;
          ld_data   = buf_q;
          buf_clear = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          pc_d      = redirect_PC;
          vld_d     = 1'b0;
          buf_clear = 1'b1;
        end
        if (imem.i_inputReady) begin
          readm_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    // every IF/ID load also advances PC to the predicted successor
    if (ifid_load) begin
      vld_d                       = 1'b1;
      {instr_d, ifpc_d, ifpred_d} = ld_data;
      pc_d                        = ld_data[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      readm_q    <= 1'b0;
      vld_q      <= 1'b0;
      instr_q    <= W'(NOP_INSTR);
      ifpc_q     <= '0;
      ifpred_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      readm_q    <= readm_d;
      vld_q      <= vld_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      ifpred_q   <= ifpred_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] num_fetched_q, num_fetched_d, num_flush_q, num_flush_d;

  always_comb begin
    num_fetched_d = num_fetched_q + {15'd0, ifid_load};
    num_flush_d   = num_flush_q + {15'd0, redirect};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_fetched_q <= '0;
      num_flush_q   <= '0;
    end else begin
      num_fetched_q <= num_fetched_d;
      num_flush_q   <= num_flush_d;
    end
  end

  assign num_fetched = num_fetched_q;
  assign num_flush   = num_flush_q;
`else
  assign num_fetched = '0;
  assign num_flush   = '0;
`endif

  assign imem.i_readM   = readm_q;
  assign imem.i_address = req_addr_q;
  assign PC             = pc_q;
  assign if_id_valid    = vld_q;
  assign if_id_instr    = instr_q;
  assign if_id_PC       = ifpc_q;
  assign if_id_pred_PC  = ifpred_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a latency-programmable imem and table predictor
module tb_fetch_unit;
  localparam logic [15:0] NOP_EXP = 16'hF01C;
  localparam logic [15:0] DKEY    = 16'h5A5A;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] PC, pred_next_PC, redirect_PC;
  logic        stall_if, redirect;
  logic        if_id_valid;
  logic [15:0] if_id_instr, if_id_PC, if_id_pred_PC, num_fetched, num_flush;
  int          lat = 2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.W(16)) mem_if ();

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem          (mem_if),
    .PC            (PC),
    .pred_next_PC  (pred_next_PC),
    .stall_if      (stall_if),
    .redirect      (redirect),
    .redirect_PC   (redirect_PC),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_PC      (if_id_PC),
    .if_id_pred_PC (if_id_pred_PC),
    .num_fetched   (num_fetched),
    .num_flush     (num_flush)
  );

  function automatic logic [15:0] pred_of(input logic [15:0] pc);
    case (pc)
      16'h0005: pred_of = 16'h0040;
      16'h0040: pred_of = 16'h0010;
      16'h0011: pred_of = 16'h0020;
      default:  pred_of = pc + 16'd1;
    endcase
  endfunction

  assign pred_next_PC = pred_of(PC);

  // memory: strobes i_inputReady in the lat-th cycle that i_readM has been high
  initial begin
    int cnt;
    cnt = 0;
    mem_if.i_inputReady = 1'b0;
    mem_if.i_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_if.i_readM) begin
        cnt = 0;
        mem_if.i_inputReady = 1'b0;
      end else begin
        cnt = cnt + 1;
        mem_if.i_inputReady = (cnt == lat);
      end
      mem_if.i_data = mem_if.i_address ^ DKEY;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_id_valid && n < 40);
    if (!if_id_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input logic [15:0] a, input logic need_ready);
    int n;
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = mem_if.i_readM && (mem_if.i_address == a) && (!need_ready || mem_if.i_inputReady);
    end while (!hit && n < 40);
    chk("addr_wait", {31'd0, hit}, 32'd1);
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] pc, input logic [15:0] pred);
    chk({tag, "_vld"}, {31'd0, if_id_valid}, 32'd1);
    chk({tag, "_pc"}, {16'd0, if_id_PC}, {16'd0, pc});
    chk({tag, "_ins"}, {16'd0, if_id_instr}, {16'd0, pc ^ DKEY});
    chk({tag, "_prd"}, {16'd0, if_id_pred_PC}, {16'd0, pred});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdm"}, {31'd0, mem_if.i_readM}, 32'd0);
    chk({tag, "_vld"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_ins"}, {16'd0, if_id_instr}, {16'd0, NOP_EXP});
    chk({tag, "_ipc"}, {16'd0, if_id_PC}, 32'd0);
    chk({tag, "_prd"}, {16'd0, if_id_pred_PC}, 32'd0);
    chk({tag, "_pc"}, {16'd0, PC}, 32'd0);
    chk({tag, "_nf"}, {16'd0, num_fetched}, 32'd0);
    chk({tag, "_nx"}, {16'd0, num_flush}, 32'd0);
  endtask

  initial begin
    int n;
    stall_if = 1'b0;
    redirect = 1'b0;
    redirect_PC = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");

    reset_n = 1'b1;
    @(negedge clk);
    chk("first_rdm", {31'd0, mem_if.i_readM}, 32'd1);
    chk("first_addr", {16'd0, mem_if.i_address}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      wait_valid(n);
      chk("gap", n, (i == 0) ? 32'd2 : 32'd3);
      chk_ifid("seq", 16'(i), (i == 5) ? 16'h0040 : 16'(i + 1));
    end

    @(negedge clk);
    chk("jmp_rdm", {31'd0, mem_if.i_readM}, 32'd1);
    chk("jmp_addr", {16'd0, mem_if.i_address}, 32'h40);
    wait_valid(n);
    chk_ifid("jmp", 16'h0040, 16'h0010);

    wait_addr(16'h0010, 1'b1);
    stall_if = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stl_rdm", {31'd0, mem_if.i_readM}, 32'd0);
      chk("stl_vld", {31'd0, if_id_valid}, 32'd0);
      chk("stl_ipc", {16'd0, if_id_PC}, 32'h40);
    end
    stall_if = 1'b0;
    @(negedge clk);
    chk_ifid("rel", 16'h0010, 16'h0011);
    @(negedge clk);
    chk("rel_dup", {31'd0, if_id_valid}, 32'd0);
    chk("rel_rdm", {31'd0, mem_if.i_readM}, 32'd1);
    chk("rel_addr", {16'd0, mem_if.i_address}, 32'h11);

    lat = 3;
    wait_addr(16'h0020, 1'b0);
    redirect = 1'b1;
    redirect_PC = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    chk("dsc_rdm", {31'd0, mem_if.i_readM}, 32'd1);
    chk("dsc_addr", {16'd0, mem_if.i_address}, 32'h20);
    chk("dsc_pc", {16'd0, PC}, 32'h100);
    chk("dsc_vld", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    chk("dsc_addr2", {16'd0, mem_if.i_address}, 32'h20);
    @(negedge clk);
    chk("dsc_drop_vld", {31'd0, if_id_valid}, 32'd0);
    chk("dsc_drop_rdm", {31'd0, mem_if.i_readM}, 32'd0);
    @(negedge clk);
    chk("dsc_new_rdm", {31'd0, mem_if.i_readM}, 32'd1);
    chk("dsc_new_addr", {16'd0, mem_if.i_address}, 32'h100);
    wait_valid(n);
    chk_ifid("r100", 16'h0100, 16'h0101);

    wait_addr(16'h0101, 1'b1);
    stall_if = 1'b1;
    redirect = 1'b1;
    redirect_PC = 16'h0200;
    @(negedge clk);
    redirect = 1'b0;
    stall_if = 1'b0;
    chk("same_vld", {31'd0, if_id_valid}, 32'd0);
    chk("same_rdm", {31'd0, mem_if.i_readM}, 32'd0);
    chk("same_pc", {16'd0, PC}, 32'h200);
    @(negedge clk);
    chk("same_addr", {16'd0, mem_if.i_address}, 32'h200);
    wait_valid(n);
    chk_ifid("r200", 16'h0200, 16'h0201);

    redirect = 1'b1;
    redirect_PC = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_pc", {16'd0, PC}, 32'hFFFF);
    @(negedge clk);
    chk("wrap_addr", {16'd0, mem_if.i_address}, 32'hFFFF);
    wait_valid(n);
    chk_ifid("wrap", 16'hFFFF, 16'h0000);
`ifdef FETCH_STATS_EN
    chk("stat_fetched", {16'd0, num_fetched}, 32'd12);
    chk("stat_flush", {16'd0, num_flush}, 32'd3);
`else
    chk("stat_fetched", {16'd0, num_fetched}, 32'd0);
    chk("stat_flush", {16'd0, num_flush}, 32'd0);
`endif
    @(negedge clk);
    chk("wrap_next", {16'd0, mem_if.i_address}, 32'd0);
    chk("wrap_rdm", {31'd0, mem_if.i_readM}, 32'd1);

    reset_n = 1'b0;
    #1;
    chk_reset_state("mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rerst_rdm", {31'd0, mem_if.i_readM}, 32'd1);
    chk("rerst_addr", {16'd0, mem_if.i_address}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage: owns the architectural PC and issues instruction-memory reads.
- Drives the current PC to branch_predictor and takes its combinational next_PC as the sequential-fetch target.
- Captures instruction, PC and predicted next PC into the IF/ID register.
- Obeys hazard stalls and resolve-stage redirects (mispredict flush), including memory responses still in flight.

Parameters:
- WORD_SIZE, 16, datapath/address width; the `WORD_SIZE macro from opcodes.v overrides the default.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_readM  out  1  instruction read request; held high until i_inputReady.
- i_address  out  16  read address; stable while i_readM=1.
- i_data  in  16  instruction word; valid when i_inputReady=1.
- i_inputReady  in  1  one-cycle memory completion strobe.
- PC  out  16  current fetch PC to branch_predictor.
- pred_next_PC  in  16  branch_predictor next_PC for PC.
- stall_if  in  1  hazard unit: hold IF/ID and PC.
- redirect  in  1  resolve stage: mispredict; flush and refetch.
- redirect_PC  in  16  correct PC from the calc_correct path.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  fetched instruction.
- if_id_PC  out  16  address of if_id_instr.
- if_id_pred_PC  out  16  predicted next PC, compared later by branch_sig.
- num_fetched  out  16  statistics (see Optional Feature).
- num_flush  out  16  statistics (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0):
  - PC=RESET_PC, state=FETCH.
  - i_readM=0 and if_id_valid=0 while reset_n=0; i_readM rises the first clk edge after release.
  - if_id_instr=`NOP_INSTR, if_id_PC=0, if_id_pred_PC=0, hold buffer invalid.
- Request rules:
  - i_address comes from req_addr, latched from PC when a request starts.
  - i_readM stays 1 until the i_inputReady cycle, then drops for at least one cycle before the next request.
  - pred_next_PC is sampled in the i_inputReady cycle (PC==req_addr then).
- FETCH state:
  - inputReady & !stall_if & !redirect: IF/ID <= {1, i_data, req_addr, pred_next_PC}; PC <= pred_next_PC; next request issued the following cycle. Throughput is 1 instruction per (memory latency + 1) cycles.
  - inputReady & stall_if & !redirect: capture the same triple into the hold buffer; go to HOLD.
  - No inputReady & !stall_if: if_id_valid <= 0 (bubble).
  - stall_if=1: all IF/ID fields hold.
- HOLD state:
  - i_readM=0.
  - When stall_if=0: IF/ID <= buffer; PC <= buffered pred; buffer invalid; go to FETCH.
- DISCARD state:
  - Entered only on a redirect with a request outstanding.
  - i_readM stays 1 with the old address until i_inputReady; the data is dropped; go to FETCH, which issues redirect_PC.
- Redirect (all states):
  - Highest priority, overrides stall_if.
  - PC <= redirect_PC; if_id_valid <= 0; hold buffer invalid.
  - FETCH with no inputReady that cycle: go to DISCARD.
  - FETCH with inputReady the same cycle: data dropped; stay in FETCH.
  - HOLD: go to FETCH.
  - DISCARD: stay in DISCARD; the latest redirect_PC wins.
- Arithmetic and edge cases:
  - PC arithmetic is mod 2^16 (0xFFFF+1 wraps to 0); sequential increment happens in the predictor.
  - A redirect equal to the current PC still flushes.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - num_fetched increments on every IF/ID load with valid=1, including HOLD release.
  - num_flush increments on every redirect cycle.
  - Both are 16-bit, wrap at 0xFFFF, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- opcodes.v holds `WORD_SIZE and `NOP_INSTR, shared with the predictor and decode.
- FSM encodings (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2) are localparams in fetch_unit.
- One sub-module: fetch_hold_buf. It is a 49-bit register with valid bit, load, clear and async reset, holding {instr, PC, pred_PC}.

Test Plan:
- Reset then memory latency 2, predictor returns PC+1, no stall: requests go to 0,1,2,3. IF/ID shows (valid, PC=0..3) each with pred = PC+1, one per 3 cycles.
- Predictor returns 0x0040 for PC=0x0005: after fetching 0x0005, the next i_address=0x0040 and if_id_pred_PC=0x0040.
- stall_if=1 for 4 cycles starting at the inputReady of PC=0x0010:
  - IF/ID keeps its prior contents and i_readM=0 during the stall.
  - After release, IF/ID=0x0010 once, with no duplicate or loss.
- redirect to 0x0100 one cycle after a request to 0x0020 is issued (latency 3):
  - i_readM stays on 0x0020 until inputReady; that data is dropped and if_id_valid=0.
  - The next request goes to 0x0100.
- redirect and inputReady in the same cycle, with stall_if=1: data dropped, if_id_valid=0, the next request goes to redirect_PC, and the stall is ignored.
- With FETCH_STATS_EN, after 10 fetches and 2 redirects: num_fetched=10, num_flush=2. Asserting reset_n=0 mid-request clears all outputs immediately and drops i_readM.
